// File: rtl/frame_buffer_reader.sv
// Display-side triple-buffer client: per frame_start it acquires a read buffer,
// fetches the frame in fixed bursts into a pixel FIFO and releases the buffer.
module frame_buffer_reader #(
    parameter int unsigned FRAME_WIDTH   = 480,
    parameter int unsigned FRAME_HEIGHT  = 272,
    parameter int unsigned BURST_LEN     = 32,
    parameter int unsigned ADDR_WIDTH    = 21,
    parameter int unsigned BUFFER_STRIDE = 'h20000,
    parameter int unsigned FIFO_DEPTH    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  read_rq_rdy,
    input  logic                  buffer_id_valid,
    input  logic [1:0]            buffer_id,
    output logic                  finalize_rd,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_ack,
    input  logic [15:0]           mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic [15:0]           pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_overrun,
    output logic                  data_error
);
    localparam int unsigned NUM_BURSTS = FRAME_WIDTH * FRAME_HEIGHT / BURST_LEN;
    localparam int unsigned BIW        = $clog2(NUM_BURSTS + 1);
    localparam int unsigned RSW        = $clog2(BURST_LEN + 1);
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, REQ_BUF, ISSUE, WAIT_DATA, DRAIN, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BIW-1:0]        burst_idx_q, burst_idx_d;
    logic [RSW-1:0]        rsv_q, rsv_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  read_rq_rdy_q, read_rq_rdy_d;
    logic                  finalize_q, finalize_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  data_error_q, data_error_d;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic                  wr_en, rd_en, space_ok;

    // A burst is only requested once the FIFO can absorb all of it.
    assign space_ok    = (32'(count_q) + 32'(rsv_q) + BURST_LEN) <= FIFO_DEPTH;
    assign mem_rd_req  = (state_q == ISSUE) && space_ok;
    assign mem_rd_addr = base_q + ADDR_WIDTH'(burst_idx_q) * ADDR_WIDTH'(BURST_LEN);
    assign pix_valid   = (count_q != '0);
    assign pix_data    = pix_valid ? mem_q[rd_ptr_q] : 16'h0;
    assign read_rq_rdy   = read_rq_rdy_q;
    assign finalize_rd   = finalize_q;
    assign busy          = busy_q;
    assign frame_overrun = overrun_q;
    assign data_error    = data_error_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        burst_idx_d  = burst_idx_q;
        rsv_d        = rsv_q;
        wr_en        = mem_rd_data_valid && (state_q == WAIT_DATA);
        rd_en        = pix_valid && pix_ready;
        overrun_d    = frame_start && (state_q != IDLE);
        data_error_d = data_error_q | (mem_rd_data_valid && (state_q != WAIT_DATA));

        case (state_q)
            IDLE:    if (frame_start) state_d = REQ_BUF;
            REQ_BUF: if (buffer_id_valid) begin
                base_d      = ADDR_WIDTH'(32'(buffer_id) * BUFFER_STRIDE);
                burst_idx_d = '0;
                state_d     = ISSUE;
            end
            ISSUE:   if (mem_rd_req && mem_rd_ack) begin
                rsv_d   = RSW'(BURST_LEN);
                state_d = WAIT_DATA;
            end
            WAIT_DATA: if (wr_en) begin
                // The reservation count doubles as the in-burst word counter.
                rsv_d = rsv_q - RSW'(1);
                if (rsv_q == RSW'(1)) begin
                    burst_idx_d = burst_idx_q + BIW'(1);
                    state_d     = (burst_idx_q == BIW'(NUM_BURSTS - 1)) ? DRAIN : ISSUE;
                end
            end
            DRAIN:   if (!pix_valid) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        read_rq_rdy_d = (state_d == REQ_BUF);
        finalize_d    = (state_d == RELEASE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            burst_idx_q   <= '0;
            rsv_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            read_rq_rdy_q <= 1'b0;
            finalize_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            data_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            burst_idx_q   <= burst_idx_d;
            rsv_q         <= rsv_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            read_rq_rdy_q <= read_rq_rdy_d;
            finalize_q    <= finalize_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            data_error_q  <= data_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= mem_rd_data;
    end
endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: table-driven frames plus randomized frames,
// scored against a frame-level model (expected pixel stream, burst addresses, FIFO occupancy).
module tb_frame_buffer_reader;
    localparam int FW = 8, FH = 2, BL = 4, AW = 21, STRIDE = 'h100, DEPTH = 8;
    localparam int NPIX = FW * FH, NB = NPIX / BL;

    logic          clk = 1'b0, reset = 1'b1, frame_start = 1'b0;
    logic          buffer_id_valid = 1'b0;
    logic [1:0]    buffer_id = 2'd0;
    logic          read_rq_rdy, finalize_rd, mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_ack = 1'b0, mem_rd_data_valid = 1'b0, pix_ready = 1'b0;
    logic [15:0]   mem_rd_data = 16'h0, pix_data;
    logic          pix_valid, busy, frame_overrun, data_error;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {
        int            gdelay;
        int            id;
        int            ready_pct;
        int            stall;
        int            ack_pct;
        int            dv_pct;
        bit            ovr;
        int            rst_at;
        logic [AW-1:0] exp_addr0;
        int            exp_rq;
    } vec_t;
    vec_t tbl [6];

    frame_buffer_reader #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .BURST_LEN(BL), .ADDR_WIDTH(AW),
        .BUFFER_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .read_rq_rdy(read_rq_rdy),
        .buffer_id_valid(buffer_id_valid), .buffer_id(buffer_id), .finalize_rd(finalize_rd),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_overrun(frame_overrun), .data_error(data_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    function automatic logic [15:0] pixf(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * AW'(37);
        return t[15:0] ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        frame_start = 0; buffer_id_valid = 0; mem_rd_ack = 0;
        mem_rd_data_valid = 0; pix_ready = 0;
        repeat (n) tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " reset_ctrl"},
            {read_rq_rdy, finalize_rd, mem_rd_req, pix_valid, busy, frame_overrun, data_error}, 7'b0);
        chk({tag, " reset_addr"}, mem_rd_addr, 0);
        chk({tag, " reset_pix"}, pix_data, 0);
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        logic [AW-1:0] exp_base, burst_addr, first_addr;
        int  rq_cnt = 0, fin_cnt = 0, popped = 0, acked = 0, delivered = 0;
        int  overruns = 0, pend = 0, last_pop = -100, fin_cyc = -100, drop_cyc = -100;
        int  t0, acked_at_stall = -1;
        bit  granted = 0, ovr_done = 0, done = 0;
        logic exp_req, dv, ack, rdy, grant;
        exp_base   = AW'(v.id * STRIDE);
        burst_addr = '0;
        first_addr = '1;
        frame_start = 1;
        tick();
        frame_start = 0;
        t0 = cyc;
        chk({tag, " rq_after_start"}, read_rq_rdy, 1);
        chk({tag, " busy_after_start"}, busy, 1);
        while (!done) begin
            if (cyc - t0 > 3000) begin
                checks++; failures++;
                $display("FAIL %s timeout: popped %0d of required %0d", tag, popped, NPIX);
                break;
            end
            // controller, memory and LCD stimulus for this cycle
            grant = read_rq_rdy && (rq_cnt == v.gdelay);
            buffer_id_valid = grant;
            buffer_id = grant ? 2'(v.id) : 2'($urandom_range(3));
            rdy = (cyc - t0 < v.stall) ? 1'b0 : ($urandom_range(99) < v.ready_pct);
            pix_ready = rdy;
            ack = mem_rd_req && ($urandom_range(99) < v.ack_pct);
            mem_rd_ack = ack;
            dv = (pend > 0) && ($urandom_range(99) < v.dv_pct);
            mem_rd_data_valid = dv;
            mem_rd_data = dv ? pixf(burst_addr + AW'(BL - pend)) : 16'($urandom);
            frame_start = v.ovr && !ovr_done && pend > 0 && acked >= 2;
            if (frame_start) ovr_done = 1;
            reset = (v.rst_at > 0) && dv && (delivered == v.rst_at - 1);

            // model-level expectations for the current cycle
            exp_req = granted && pend == 0 && acked < NB && (delivered - popped + BL <= DEPTH);
            chk({tag, " mem_rd_req"}, mem_rd_req, exp_req);
            chk({tag, " pix_valid"}, pix_valid, delivered != popped);
            if (read_rq_rdy) rq_cnt++;
            if (finalize_rd) begin fin_cnt++; fin_cyc = cyc; end
            if (frame_overrun) overruns++;
            if (rdy && pix_valid) begin
                chk({tag, " pix_data"}, pix_data, pixf(exp_base + AW'(popped)));
                popped++;
                last_pop = cyc;
            end
            if (dv) begin delivered++; pend--; end
            if (ack) begin
                if (acked == 0) first_addr = mem_rd_addr;
                chk({tag, " burst_addr"}, mem_rd_addr, exp_base + AW'(acked * BL));
                burst_addr = mem_rd_addr;
                acked++;
                pend = BL;
            end
            if (fin_cnt > 0 && !busy) begin done = 1; drop_cyc = cyc; end
            if (v.stall > 0 && cyc - t0 == v.stall) acked_at_stall = acked;
            if (grant) granted = 1;
            tick();
            frame_start = 0;
            if (reset) begin
                reset = 0;
                check_reset_values({tag, " mid_burst"});
                idle(0);
                for (int i = 0; i < 4; i++) begin
                    chk({tag, " no_finalize_after_reset"}, {finalize_rd, busy}, 2'b00);
                    tick();
                end
                return;
            end
        end
        idle(0);
        chk({tag, " popped"}, popped, NPIX);
        chk({tag, " bursts"}, acked, NB);
        chk({tag, " first_addr"}, first_addr, v.exp_addr0);
        chk({tag, " rq_cycles"}, rq_cnt, v.exp_rq);
        chk({tag, " finalize_count"}, fin_cnt, 1);
        chk({tag, " finalize_after_last_pop"}, fin_cyc - last_pop, 2);
        chk({tag, " busy_drop_after_last_pop"}, drop_cyc - last_pop, 3);
        chk({tag, " overruns"}, overruns, v.ovr ? 1 : 0);
        chk({tag, " data_error"}, data_error, 0);
        if (v.stall > 0) chk({tag, " bursts_during_stall"}, acked_at_stall, 2);
        idle(2);
    endtask

    initial begin
        vec_t rv;
        //        gdly id rdy stall ack dv ovr rst  addr0      rq
        tbl[0] = '{1, 2, 100, 0,  100, 100, 1'b0, 0, 21'h200, 2};   // basic
        tbl[1] = '{5, 0, 100, 0,  100, 100, 1'b0, 0, 21'h000, 6};   // delayed grant
        tbl[2] = '{1, 1, 100, 20, 100, 100, 1'b0, 0, 21'h100, 2};   // backpressure
        tbl[3] = '{2, 2, 100, 0,  100, 100, 1'b1, 0, 21'h200, 3};   // overrun
        tbl[4] = '{1, 2, 100, 0,  100, 100, 1'b0, 2, 21'h200, 2};   // reset mid-burst
        tbl[5] = '{0, 1, 70,  0,  60,  80,  1'b0, 0, 21'h100, 1};   // clean frame after reset

        reset = 1;
        tick();
        check_reset_values("por");
        tick();
        reset = 0;
        idle(2);
        check_reset_values("idle");

        for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

        // stray data strobe while idle
        mem_rd_data_valid = 1; mem_rd_data = 16'hBEEF;
        tick();
        mem_rd_data_valid = 0;
        chk("stray data_error", data_error, 1);
        chk("stray fifo_empty", pix_valid, 0);
        idle(5);
        chk("stray sticky", data_error, 1);
        chk("stray still_empty", {pix_valid, busy}, 2'b00);

        run_frame("vec4", tbl[4]);
        run_frame("vec5", tbl[5]);

        for (int r = 0; r < 6; r++) begin
            rv.gdelay    = $urandom_range(4);
            rv.id        = $urandom_range(2);
            rv.ready_pct = $urandom_range(100, 30);
            rv.stall     = 0;
            rv.ack_pct   = $urandom_range(100, 20);
            rv.dv_pct    = $urandom_range(100, 30);
            rv.ovr       = 1'($urandom_range(1));
            rv.rst_at    = 0;
            rv.exp_addr0 = AW'(rv.id * STRIDE);
            rv.exp_rq    = rv.gdelay + 1;
            run_frame($sformatf("rand%0d", r), rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
